// File: rtl/univ_shift_reg_pkg.sv
// Shared mode encoding and sizing helper for the universal shift register.
package univ_shift_reg_pkg;

    typedef enum logic [2:0] {
        MODE_HOLD = 3'd0,
        MODE_SHR  = 3'd1,
        MODE_SHL  = 3'd2,
        MODE_ROTR = 3'd3,
        MODE_ROTL = 3'd4,
        MODE_LOAD = 3'd5
    } mode_e;

    // Step counter width; never narrower than one bit.
    function automatic int cnt_width(input int steps);
        return (steps > 2) ? $clog2(steps) : 1;
    endfunction

endpackage

// File: rtl/univ_shift_step_ctr.sv
// Frame step counter: counts shift steps since the last load and pulses done
// for the cycle after the count wraps from STEPS-1 to 0.
module univ_shift_step_ctr
    import univ_shift_reg_pkg::*;
#(
    parameter int STEPS = 8
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         load,
    input  logic                         step,
    output logic [cnt_width(STEPS)-1:0]  cnt,
    output logic                         done
);

    localparam int              CW   = cnt_width(STEPS);
    localparam logic [CW-1:0]   LAST = CW'(STEPS - 1);

    logic wrap;

    assign wrap = step && (cnt == LAST);

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt  <= '0;
            done <= 1'b0;
        end else begin
            done <= wrap;
            if (load)
                cnt <= '0;
            else if (step)
                cnt <= wrap ? '0 : cnt + CW'(1);
        end
    end

endmodule

// File: rtl/univ_shift_reg.sv
// Universal shift/rotate/load register with a frame step counter.
// Optional parity output enabled by defining UNIV_SHIFT_REG_PARITY_EN.
module univ_shift_reg
    import univ_shift_reg_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int LANE  = 1
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                en,
    input  logic [2:0]                          mode,
    input  logic [LANE-1:0]                     sin_r,
    input  logic [LANE-1:0]                     sin_l,
    input  logic [WIDTH-1:0]                    pin,
    output logic [WIDTH-1:0]                    pout,
    output logic [LANE-1:0]                     sout_r,
    output logic [LANE-1:0]                     sout_l,
    output logic [cnt_width(WIDTH/LANE)-1:0]    cnt,
`ifdef UNIV_SHIFT_REG_PARITY_EN
    output logic                                parity,
`endif
    output logic                                done
);

    localparam int STEPS = WIDTH / LANE;

    generate
        if (LANE < 1 || (WIDTH % LANE) != 0 || STEPS < 2) begin : g_bad_cfg
            $error("univ_shift_reg: WIDTH must be a multiple of LANE with WIDTH/LANE >= 2");
        end
    endgenerate

    mode_e              op;
    logic [WIDTH-1:0]   q;
    logic [WIDTH-1:0]   q_next;
    logic               is_shift;
    logic               is_load;

    assign op = mode_e'(mode);

    // NOTE: q_next gets its default before the case so no path leaves it
    // unassigned and no latch is inferred.
    always_comb begin
        q_next   = q;
        is_shift = 1'b0;
        is_load  = 1'b0;
        case (op)
            MODE_SHR: begin
                q_next   = {sin_r, q[WIDTH-1:LANE]};
                is_shift = 1'b1;
            end
            MODE_SHL: begin
                q_next   = {q[WIDTH-LANE-1:0], sin_l};
                is_shift = 1'b1;
            end
            MODE_ROTR: begin
                q_next   = {q[LANE-1:0], q[WIDTH-1:LANE]};
                is_shift = 1'b1;
            end
            MODE_ROTL: begin
                q_next   = {q[WIDTH-LANE-1:0], q[WIDTH-1:WIDTH-LANE]};
                is_shift = 1'b1;
            end
            MODE_LOAD: begin
                q_next  = pin;
                is_load = 1'b1;
            end
            default: ;  // HOLD and reserved codes keep q
        endcase
    end

    // NOTE: reset is asynchronous so outputs clear while rst is high, before
    // any clock edge arrives.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            q <= '0;
        else if (en)
            q <= q_next;
    end

    univ_shift_step_ctr #(
        .STEPS (STEPS)
    ) u_step_ctr (
        .clk   (clk),
        .rst   (rst),
        .load  (en && is_load),
        .step  (en && is_shift),
        .cnt   (cnt),
        .done  (done)
    );

    assign pout   = q;
    assign sout_r = q[LANE-1:0];
    assign sout_l = q[WIDTH-1:WIDTH-LANE];

`ifdef UNIV_SHIFT_REG_PARITY_EN
    assign parity = ^q;
`endif

endmodule

// File: doc/univ_shift_reg.md
UNIV_SHIFT_REG -- requirements
Module: univ_shift_reg

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, giving register width in bits.
REQ-002 The block SHALL have parameter LANE, default 1, giving bits moved per shift step.
REQ-003 WIDTH SHALL be a multiple of LANE, with STEPS = WIDTH/LANE >= 2; an illegal setting SHALL stop elaboration.
REQ-004 clk  input  1  sole clock; all state updates on rising edge.
REQ-005 rst  input  1  asynchronous, active-high reset.
REQ-006 en  input  1  operation enable; low = hold.
REQ-007 mode  input  3  operation select, encoded per REQ-013.
REQ-008 sin_r  input  LANE  serial data entering the MSB end on right shifts.
REQ-009 sin_l  input  LANE  serial data entering the LSB end on left shifts.
REQ-010 pin  input  WIDTH  parallel load data.
REQ-011 pout  output  WIDTH  register contents q.
REQ-012 Output sout_r (LANE) SHALL equal q[LANE-1:0]; sout_l (LANE) SHALL equal q[WIDTH-1:WIDTH-LANE]; cnt (clog2(STEPS)) gives shift steps since the last load; done (1) is the frame-complete pulse.

Function
REQ-013 Mode encoding: 0 HOLD, 1 SHR, 2 SHL, 3 ROTR, 4 ROTL, 5 LOAD, 6/7 reserved; reserved codes SHALL behave as HOLD.
REQ-014 With en=1, each mode SHALL update q on the rising edge as follows:
- SHR: q <= {sin_r, q[WIDTH-1:LANE]}
- SHL: q <= {q[WIDTH-LANE-1:0], sin_l}
- ROTR: q <= {q[LANE-1:0], q[WIDTH-1:LANE]}
- ROTL: q <= {q[WIDTH-LANE-1:0], q[WIDTH-1:WIDTH-LANE]}
- LOAD: q <= pin
REQ-015 With en=0, q, cnt and done SHALL hold, except that done SHALL still clear per REQ-018.
REQ-016 sout_r, sout_l and pout SHALL be combinational from q; they are valid in the same cycle with no added latency.
REQ-017 On LOAD with en=1, cnt SHALL become 0. Each enabled shift or rotate SHALL increment cnt, wrapping from STEPS-1 to 0.
REQ-018 done SHALL be registered and SHALL be high for exactly the one cycle after the edge on which cnt wraps from STEPS-1 to 0; otherwise done SHALL be 0.
REQ-019 HOLD and reserved modes SHALL leave cnt unchanged.
REQ-020 Direction changes mid-frame (for example SHR then SHL) SHALL count uniformly; no per-direction counter exists.

Reset
REQ-021 While rst=1, q, cnt and done SHALL be 0 immediately, without waiting for a clock edge; therefore pout, sout_r and sout_l are also 0.
REQ-022 Reset asserted mid-frame SHALL discard the partial frame; the first enabled shift after release SHALL give cnt=1.

Configuration
REQ-023 With macro UNIV_SHIFT_REG_PARITY_EN defined, the block SHALL add output parity (1) equal to the XOR of all bits of q, combinational and 0 in reset.
REQ-024 Without UNIV_SHIFT_REG_PARITY_EN, the parity port and its logic SHALL be absent.

Structure
REQ-025 Package univ_shift_reg_pkg SHALL hold the mode typedef enum (3-bit) and its encoding constants.
REQ-026 The step counter and done-pulse logic SHALL be a sub-module, univ_shift_step_ctr, parameterised by STEPS.

Verification
REQ-027 Reset: rst=1 at t=0 with pin=8'hFF, mode=LOAD -> pout=8'h00, cnt=0, done=0, with no clock edge required.
REQ-028 Serialise: WIDTH=8, LANE=1; LOAD 8'hA5, then 8 SHR with sin_r=0 -> sout_r sequence 1,0,1,0,0,1,0,1; final pout=8'h00; done high for exactly one cycle after the 8th shift.
REQ-029 Rotate: LOAD 8'h81, one ROTL -> pout=8'h03; after 8 ROTL total -> pout=8'h81 and one done pulse.
REQ-030 Hold and reserved: after LOAD 8'h3C, mode=SHR with en=0 for 5 cycles, then mode=6 with en=1 for 2 cycles -> pout=8'h3C and cnt=0 throughout.
REQ-031 Async reset mid-frame: reset asserted between edges at cnt=3 -> pout=0 and cnt=0 before the next edge; after release, one SHR -> cnt=1.
REQ-032 Wide lane: WIDTH=16, LANE=4; LOAD 16'h1234, then 2 SHL with sin_l=4'hF -> sout_l shows 4'h1 then 4'h2, pout=16'h34FF; done after the 4th shift. With UNIV_SHIFT_REG_PARITY_EN, 8'hA5 loaded -> parity=0.
